// File: rtl/lvdc_serial_capture_if.sv
// Output word handshake between the LVDC serial capture and a telemetry consumer.
interface lvdc_serial_capture_if #(
  parameter int unsigned NCH   = 1,
  parameter int unsigned WIDTH = 26
);
  logic [NCH*WIDTH-1:0] WORD;
  logic                 WVALID;
  logic                 ACK;

  // Capture side: presents the word and waits for ACK.
  modport master (output WORD, output WVALID, input ACK);
  // Consumer side: accepts the word with ACK.
  modport slave  (input WORD, input WVALID, output ACK);
endinterface

// File: rtl/lvdc_serial_capture.sv
// LVDC serial telemetry capture: PBV frames, WDA bit strobes, NCH parallel data lines.
module lvdc_serial_capture #(
  parameter int unsigned WIDTH       = 26,
  parameter int unsigned NCH         = 1,
  parameter int unsigned LEAD_BITS   = 1,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           SIM_CLK,
  input  logic           SIM_RST,
  input  logic           PBV,
  input  logic           WDA,
  input  logic [NCH-1:0] DIN,
  input  logic           CLR_ERR,
  output logic           BUSY,
  output logic           OVR,
  output logic           FERR,
  lvdc_serial_capture_if.master o_bus
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT} state_t;

  logic [SYNC_STAGES-1:0]          r_pbv_sync;
  logic [SYNC_STAGES-1:0]          r_wda_sync;
  logic [SYNC_STAGES-1:0][NCH-1:0] r_din_sync;
  logic                            r_wda_dly;
  logic                            r_pbv_prev;
  state_t                          r_state;
  logic [3:0]                      r_lead_cnt;
  logic [CW-1:0]                   r_bit_cnt;
  logic [NCH-1:0][WIDTH-1:0]       r_sr;
  logic                            r_done;
  logic                            r_busy;
  logic                            r_ferr;
  logic                            r_ovr;
  logic [NCH*WIDTH-1:0]            r_word;
  logic                            r_wvalid;

  logic           w_pbv_s;
  logic           w_wda_s;
  logic [NCH-1:0] w_din_s;
  logic           w_stb;
  logic           w_pbv_rise;

  assign w_pbv_s    = r_pbv_sync[SYNC_STAGES-1];
  assign w_wda_s    = r_wda_sync[SYNC_STAGES-1];
  assign w_din_s    = r_din_sync[SYNC_STAGES-1];
  assign w_stb      = w_wda_s & ~r_wda_dly;
  assign w_pbv_rise = w_pbv_s & ~r_pbv_prev;

  assign BUSY          = r_busy;
  assign OVR           = r_ovr;
  assign FERR          = r_ferr;
  assign o_bus.WORD    = r_word;
  assign o_bus.WVALID  = r_wvalid;

  // Equal-depth synchronisers keep DIN aligned with the WDA strobe.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      r_pbv_sync <= '0;
      r_wda_sync <= '0;
      r_din_sync <= '0;
      r_wda_dly  <= 1'b0;
    end else begin
      r_pbv_sync <= {r_pbv_sync[SYNC_STAGES-2:0], PBV};
      r_wda_sync <= {r_wda_sync[SYNC_STAGES-2:0], WDA};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], DIN};
      r_wda_dly  <= w_wda_s;
    end
  end

  // Frame FSM: advances only on strobe cycles; a PBV rise always restarts the frame.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      r_state    <= S_IDLE;
      r_lead_cnt <= '0;
      r_bit_cnt  <= '0;
      r_sr       <= '0;
      r_pbv_prev <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (CLR_ERR) r_ferr <= 1'b0;
      if (w_stb) begin
        r_pbv_prev <= w_pbv_s;
        if (w_pbv_rise) begin
          if (r_state != S_IDLE) r_ferr <= 1'b1;
          r_sr      <= '0;
          r_bit_cnt <= '0;
          r_busy    <= 1'b1;
          if (LEAD_BITS == 0) begin
            r_state <= S_SHIFT;
          end else begin
            r_state    <= S_LEAD;
            r_lead_cnt <= 4'(LEAD_BITS);
          end
        end else begin
          case (r_state)
            S_LEAD: begin
              r_lead_cnt <= r_lead_cnt - 4'd1;
              if (r_lead_cnt == 4'd1) r_state <= S_SHIFT;
            end
            S_SHIFT: begin
              for (int c = 0; c < int'(NCH); c++) begin
                if (MSB_FIRST != 0) r_sr[c] <= {r_sr[c][WIDTH-2:0], w_din_s[c]};
                else                r_sr[c] <= {w_din_s[c], r_sr[c][WIDTH-1:1]};
              end
              if (r_bit_cnt == CW'(WIDTH - 1)) begin
                r_bit_cnt <= '0;
                r_done    <= 1'b1;
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
              end else begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Output word register with valid/ack handshake; newest word wins on overrun.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      r_word   <= '0;
      r_wvalid <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (CLR_ERR) r_ovr <= 1'b0;
      if (r_done) begin
        r_word   <= r_sr;
        r_wvalid <= 1'b1;
        if (r_wvalid && !o_bus.ACK) r_ovr <= 1'b1;
      end else if (r_wvalid && o_bus.ACK) begin
        r_wvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lvdc_serial_capture.sv
// Directed bench for lvdc_serial_capture: default, 3-channel and LSB-first instances.
module tb_lvdc_serial_capture;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic pbv_a = 1'b0, wda_a = 1'b0, clr_a = 1'b0;
  logic [0:0] din_a = '0;
  logic busy_a, ovr_a, ferr_a;
  lvdc_serial_capture_if #(.NCH(1), .WIDTH(26)) bus_a ();

  // DUT B (3 ch, MSB first) and DUT C (LSB first) share PBV/WDA
  logic pbv_b = 1'b0, wda_b = 1'b0, clr_b = 1'b0;
  logic [2:0] din_b = '0;
  logic [0:0] din_c = '0;
  logic busy_b, ovr_b, ferr_b, busy_c, ovr_c, ferr_c;
  lvdc_serial_capture_if #(.NCH(3), .WIDTH(8)) bus_b ();
  lvdc_serial_capture_if #(.NCH(1), .WIDTH(8)) bus_c ();

  lvdc_serial_capture u_a (
    .SIM_CLK(clk), .SIM_RST(rst_n), .PBV(pbv_a), .WDA(wda_a), .DIN(din_a),
    .CLR_ERR(clr_a), .BUSY(busy_a), .OVR(ovr_a), .FERR(ferr_a), .o_bus(bus_a)
  );

  lvdc_serial_capture #(.WIDTH(8), .NCH(3), .LEAD_BITS(0), .MSB_FIRST(1)) u_b (
    .SIM_CLK(clk), .SIM_RST(rst_n), .PBV(pbv_b), .WDA(wda_b), .DIN(din_b),
    .CLR_ERR(clr_b), .BUSY(busy_b), .OVR(ovr_b), .FERR(ferr_b), .o_bus(bus_b)
  );

  lvdc_serial_capture #(.WIDTH(8), .NCH(1), .LEAD_BITS(0), .MSB_FIRST(0)) u_c (
    .SIM_CLK(clk), .SIM_RST(rst_n), .PBV(pbv_b), .WDA(wda_b), .DIN(din_c),
    .CLR_ERR(clr_b), .BUSY(busy_c), .OVR(ovr_c), .FERR(ferr_c), .o_bus(bus_c)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One WDA strobe on DUT A, 3 clocks high then 3 low.
  task automatic strobe_a(input logic d);
    din_a = d;
    tick(1);
    wda_a = 1'b1;
    tick(3);
    wda_a = 1'b0;
    tick(3);
  endtask

  task automatic strobe_bc(input logic [2:0] db, input logic dc);
    din_b = db;
    din_c = dc;
    tick(1);
    wda_b = 1'b1;
    tick(3);
    wda_b = 1'b0;
    tick(3);
  endtask

  // Frame start + lead strobe on DUT A.
  task automatic start_a();
    pbv_a = 1'b1;
    strobe_a(1'b0);
    pbv_a = 1'b0;
    strobe_a(1'b1);
  endtask

  // First nbits of a 26-bit word, MSB first, on DUT A.
  task automatic bits_a(input logic [25:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) strobe_a(w[25-i]);
  endtask

  task automatic ack_a();
    bus_a.ACK = 1'b1;
    tick(1);
    bus_a.ACK = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] w;
    logic [7:0]  c0, c1, c2;
    bus_a.ACK = 1'b0;
    bus_b.ACK = 1'b0;
    bus_c.ACK = 1'b0;

    // Reset state
    tick(3);
    check("rst_word",   64'(bus_a.WORD), 64'h0);
    check("rst_wvalid", 64'(bus_a.WVALID), 64'h0);
    check("rst_flags",  64'({busy_a, ovr_a, ferr_a}), 64'h0);
    rst_n = 1'b1;
    tick(2);

    // Test 1: default frame, latency of WVALID after the last strobe
    w = 26'h2AAAAAA;
    pbv_a = 1'b1;
    strobe_a(1'b0);
    pbv_a = 1'b0;
    check("t1_busy_lead", 64'(busy_a), 64'h1);
    strobe_a(1'b1);
    bits_a(w, 25);
    check("t1_busy_shift", 64'(busy_a), 64'h1);
    din_a = w[0];
    tick(1);
    wda_a = 1'b1;
    tick(3);
    check("t1_wvalid_e3", 64'(bus_a.WVALID), 64'h0);
    tick(1);
    check("t1_wvalid_e4", 64'(bus_a.WVALID), 64'h1);
    wda_a = 1'b0;
    tick(3);
    check("t1_word", 64'(bus_a.WORD), 64'h2AAAAAA);
    check("t1_busy", 64'(busy_a), 64'h0);
    check("t1_errs", 64'({ovr_a, ferr_a}), 64'h0);
    ack_a();
    check("t1_ack", 64'(bus_a.WVALID), 64'h0);
    check("t1_word_hold", 64'(bus_a.WORD), 64'h2AAAAAA);

    // Tests 2/3: 3-channel MSB first and single-channel LSB first
    c0 = 8'hA5; c1 = 8'h3C; c2 = 8'hFF;
    pbv_b = 1'b1;
    strobe_bc(3'b000, 1'b0);
    pbv_b = 1'b0;
    for (int i = 0; i < 8; i++) strobe_bc({c2[7-i], c1[7-i], c0[7-i]}, (i == 0));
    check("t2_word",   64'(bus_b.WORD), 64'hFF3CA5);
    check("t2_wvalid", 64'(bus_b.WVALID), 64'h1);
    check("t3_word",   64'(bus_c.WORD), 64'h01);
    check("t3_busy",   64'(busy_c), 64'h0);

    // Test 4: back-to-back frames without ACK -> overrun, newest wins
    start_a();
    bits_a(26'h1234567, 26);
    check("t4_word1", 64'(bus_a.WORD), 64'h1234567);
    check("t4_ovr0",  64'(ovr_a), 64'h0);
    start_a();
    bits_a(26'h0000001, 26);
    check("t4_word2",  64'(bus_a.WORD), 64'h0000001);
    check("t4_ovr1",   64'(ovr_a), 64'h1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("t4_ovr_clr",   64'(ovr_a), 64'h0);
    check("t4_wvalid_hd", 64'(bus_a.WVALID), 64'h1);
    ack_a();
    check("t4_ack", 64'(bus_a.WVALID), 64'h0);

    // Test 5: PBV re-rise mid-frame -> frame error, then full frame
    start_a();
    bits_a(26'h0F0F0F0, 10);
    check("t5_ferr0", 64'(ferr_a), 64'h0);
    pbv_a = 1'b1;
    strobe_a(1'b0);
    pbv_a = 1'b0;
    check("t5_ferr1", 64'(ferr_a), 64'h1);
    strobe_a(1'b1);
    bits_a(26'h3FFFFFF, 26);
    check("t5_word", 64'(bus_a.WORD), 64'h3FFFFFF);
    check("t5_ovr",  64'(ovr_a), 64'h0);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("t5_ferr_clr", 64'(ferr_a), 64'h0);

    // Test 6: reset mid-frame, stray strobes, then clean frame
    start_a();
    bits_a(26'h2AAAAAA, 5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_word", 64'(bus_a.WORD), 64'h0);
    check("t6_rst_outs", 64'({bus_a.WVALID, busy_a, ovr_a, ferr_a}), 64'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) strobe_a(1'b1);
    check("t6_busy",   64'(busy_a), 64'h0);
    check("t6_wvalid", 64'(bus_a.WVALID), 64'h0);
    start_a();
    bits_a(26'h155AA33, 26);
    check("t6_word", 64'(bus_a.WORD), 64'h155AA33);
    check("t6_errs", 64'({ovr_a, ferr_a}), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
